// File: rtl/instr_fetch.sv
// Instruction fetch and issue unit: owns the PC, fetches one word at a time over a
// req/gnt/rvalid interface, holds it for the control unit and computes the next PC.
package instr_fetch_pkg;
    typedef enum logic [1:0] {
        OP_JP  = 2'b00,
        OP_BR  = 2'b01,
        OP_ALU = 2'b10,
        OP_MEM = 2'b11
    } op_t;

    typedef enum logic {
        PC_INC = 1'b0,
        PC_ADD = 1'b1
    } pc_s_t;
endpackage

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                  ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [15:0]       imem_rdata,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [1:0]        operation,
    output logic [2:0]        funct,
    output logic [2:0]        rx,
    output logic [2:0]        ry,
    output logic [7:0]        kk,
    output logic [ADDR_W-1:0] pc,
    input  pc_s_t             pc_s,
    input  logic              br_taken,
    input  logic              halt,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_WAIT   = 2'b01,
        S_ISSUE  = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_active;
    logic [ADDR_W-1:0]   r_pc;
    logic [15:0]         r_ir;

    logic                w_load_ir;
    logic                w_issue_hs;
    op_t                 w_op;
    logic [ADDR_W-1:0]   w_jp_off;
    logic [ADDR_W-1:0]   w_br_off;
    logic [ADDR_W-1:0]   w_next_pc;

    // r_active keeps imem_req low while reset is held and for the remainder of the
    // release cycle, so the first request appears on the first edge after release.
    assign imem_req   = r_active && (r_state == S_FETCH);
    assign ir_valid   = (r_state == S_ISSUE);
    assign halted     = (r_state == S_HALTED);
    assign w_issue_hs = ir_valid && ir_ready;

    assign imem_addr  = r_pc;
    assign pc         = r_pc;

    assign operation  = r_ir[15:14];
    assign funct      = r_ir[13:11];
    assign rx         = r_ir[10:8];
    assign ry         = r_ir[7:5];
    assign kk         = r_ir[7:0];

    assign w_op       = op_t'(r_ir[15:14]);
    assign w_jp_off   = {{(ADDR_W-11){r_ir[10]}}, r_ir[10:0]};
    assign w_br_off   = {{(ADDR_W-8){r_ir[7]}}, r_ir[7:0]};

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_active <= 1'b0;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
        end else begin
            r_state  <= w_next_state;
            r_active <= 1'b1;
            if (w_issue_hs) begin
                r_pc <= w_next_pc;
            end
            if (w_load_ir) begin
                r_ir <= imem_rdata;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_load_ir    = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (imem_req && imem_gnt) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_load_ir    = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ir_ready) begin
                    w_next_state = halt ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: begin
                if (!halt) begin
                    w_next_state = S_FETCH;
                end
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // Sums wrap silently at the address width.
    always_comb begin
        w_next_pc = r_pc + ADDR_W'(1);
        if (pc_s == PC_ADD) begin
            if (w_op == OP_JP) begin
                w_next_pc = r_pc + w_jp_off;
            end else if ((w_op == OP_BR) && br_taken) begin
                w_next_pc = r_pc + w_br_off;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected fetch addresses and
// issued instructions; a negedge monitor compares them against the DUT handshakes.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [1:0]  operation;
    logic [2:0]  funct;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [7:0]  kk;
    logic [15:0] pc;
    pc_s_t       pc_s;
    logic        br_taken;
    logic        halt;
    logic        halted;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
    } iss_t;

    logic [15:0] addr_q[$];
    iss_t        iss_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t_valid;
    int t_prev;

    instr_fetch #(
        .ADDR_W   (16),
        .RESET_PC (16'h0010)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .operation   (operation),
        .funct       (funct),
        .rx          (rx),
        .ry          (ry),
        .kk          (kk),
        .pc          (pc),
        .pc_s        (pc_s),
        .br_taken    (br_taken),
        .halt        (halt),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every granted fetch and every retired instruction must match the queues.
    always @(negedge clk) begin : monitor
        logic [15:0] e_addr;
        iss_t        e_iss;
        if (rst_n && imem_req && imem_gnt) begin
            if (addr_q.size() == 0) begin
                check("unexpected_fetch", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                e_addr = addr_q.pop_front();
                check("fetch_addr", 32'(imem_addr), 32'(e_addr));
            end
        end
        if (rst_n && ir_valid && ir_ready) begin
            if (iss_q.size() == 0) begin
                check("unexpected_issue", 32'(pc), 32'hFFFF_FFFF);
            end else begin
                e_iss = iss_q.pop_front();
                check("issue_pc",        32'(pc),        32'(e_iss.addr));
                check("issue_operation", 32'(operation), 32'(e_iss.instr[15:14]));
                check("issue_funct",     32'(funct),     32'(e_iss.instr[13:11]));
                check("issue_rx",        32'(rx),        32'(e_iss.instr[10:8]));
                check("issue_ry",        32'(ry),        32'(e_iss.instr[7:5]));
                check("issue_kk",        32'(kk),        32'(e_iss.instr[7:0]));
            end
        end
    end

    // One complete instruction: optional spurious rvalid, grant delay, response,
    // optional back-pressure, then the issue handshake with the given next-PC controls.
    task automatic fetch_one(input logic [15:0] addr, input logic [15:0] instr,
                             input pc_s_t sel, input logic br, input int gnt_dly,
                             input int rdy_dly, input logic hlt, input logic spur);
        int          n;
        logic [15:0] f_pc;
        logic [7:0]  f_kk;
        logic [2:0]  f_rx;
        iss_t        item;
        item.addr  = addr;
        item.instr = instr;
        addr_q.push_back(addr);
        iss_q.push_back(item);
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        if (!imem_req) begin
            check("req_timeout", 32'(imem_req), 32'd1);
            return;
        end
        if (spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 16'hFFFF;
            step();
            imem_rvalid = 1'b0;
            check("spur_no_valid", 32'(ir_valid), 32'd0);
            check("spur_req_held", 32'(imem_req), 32'd1);
        end
        for (int i = 0; i < gnt_dly; i++) begin
            step();
            check("gnt_wait_addr", 32'(imem_addr), 32'(addr));
            check("gnt_wait_req",  32'(imem_req),  32'd1);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("wait_no_req", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = instr;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 16'hDEAD;
        check("ir_valid_rise", 32'(ir_valid), 32'd1);
        t_valid = cyc;
        f_pc = pc;
        f_kk = kk;
        f_rx = rx;
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            check("stall_valid", 32'(ir_valid), 32'd1);
            check("stall_no_req", 32'(imem_req), 32'd0);
            check("stall_pc", 32'(pc), 32'(f_pc));
            check("stall_kk", 32'(kk), 32'(f_kk));
            check("stall_rx", 32'(rx), 32'(f_rx));
        end
        pc_s     = sel;
        br_taken = br;
        halt     = hlt;
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        pc_s     = PC_INC;
        br_taken = 1'b0;
        if (!hlt) begin
            check("req_after_issue", 32'(imem_req), 32'd1);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'h0000;
        ir_ready    = 1'b0;
        pc_s        = PC_INC;
        br_taken    = 1'b0;
        halt        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",      32'(imem_req),  32'd0);
        check("rst_addr",     32'(imem_addr), 32'h0010);
        check("rst_pc",       32'(pc),        32'h0010);
        check("rst_ir_valid", 32'(ir_valid),  32'd0);
        check("rst_halted",   32'(halted),    32'd0);
        check("rst_kk",       32'(kk),        32'd0);
        check("rst_op",       32'(operation), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_req_yet", 32'(imem_req), 32'd0);
        step();
        check("first_req", 32'(imem_req), 32'd1);

        // Sequential fetch at the minimum 3-cycle period.
        fetch_one(16'h0010, 16'h8123, PC_INC, 1'b0, 0, 0, 1'b0, 1'b0);
        t_prev = t_valid;
        fetch_one(16'h0011, 16'hA5F7, PC_INC, 1'b0, 0, 0, 1'b0, 1'b0);
        check("period_1", 32'(t_valid - t_prev), 32'd3);
        t_prev = t_valid;
        fetch_one(16'h0012, 16'h4C3A, PC_INC, 1'b0, 0, 0, 1'b0, 1'b0);
        check("period_2", 32'(t_valid - t_prev), 32'd3);

        // Jumps: forward to 0x20, backward by 2, then on to 0x40 under back-pressure.
        fetch_one(16'h0013, 16'h000D, PC_ADD, 1'b0, 0, 0, 1'b0, 1'b0);
        fetch_one(16'h0020, 16'h3FFE, PC_ADD, 1'b0, 0, 0, 1'b0, 1'b0);
        fetch_one(16'h001E, 16'h0022, PC_ADD, 1'b0, 0, 5, 1'b0, 1'b0);

        // Branch taken, jump back with a delayed grant, branch not taken.
        fetch_one(16'h0040, 16'h4005, PC_ADD, 1'b1, 0, 0, 1'b0, 1'b0);
        fetch_one(16'h0045, 16'h07FB, PC_ADD, 1'b0, 4, 0, 1'b0, 1'b0);
        fetch_one(16'h0040, 16'h4005, PC_ADD, 1'b0, 0, 0, 1'b0, 1'b0);

        // Spurious rvalid in FETCH; PC_ADD on a non-control op; branch with PC_INC.
        fetch_one(16'h0041, 16'h8005, PC_ADD, 1'b1, 0, 0, 1'b0, 1'b1);
        fetch_one(16'h0042, 16'h40FF, PC_INC, 1'b1, 0, 0, 1'b0, 1'b0);

        // halt held during FETCH/WAIT must not stop this instruction.
        halt = 1'b1;
        fetch_one(16'h0043, 16'h07BC, PC_ADD, 1'b0, 0, 0, 1'b0, 1'b0);
        check("halt_ignored_in_fetch", 32'(halted), 32'd0);

        // Wrap from 0xFFFF to 0x0000 and halt at the handshake.
        fetch_one(16'hFFFF, 16'hC123, PC_INC, 1'b0, 0, 0, 1'b1, 1'b0);
        check("halted_set",   32'(halted),   32'd1);
        check("halted_noreq", 32'(imem_req), 32'd0);
        check("wrap_pc",      32'(pc),       32'h0000);
        repeat (3) step();
        check("halted_hold",  32'(halted),   32'd1);
        check("halted_noreq2", 32'(imem_req), 32'd0);
        check("halted_pc",    32'(pc),       32'h0000);
        halt = 1'b0;
        step();
        check("resume_req",    32'(imem_req),  32'd1);
        check("resume_addr",   32'(imem_addr), 32'h0000);
        check("resume_halted", 32'(halted),    32'd0);

        // Zero-offset jump re-fetches the same address.
        fetch_one(16'h0000, 16'h0000, PC_ADD, 1'b0, 0, 0, 1'b0, 1'b0);
        fetch_one(16'h0000, 16'h8888, PC_INC, 1'b0, 0, 0, 1'b0, 1'b0);

        // Async reset while waiting for a response.
        addr_q.push_back(16'h0001);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("pre_reset_wait", 32'(imem_req), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",      32'(imem_req),  32'd0);
        check("arst_pc",       32'(pc),        32'h0010);
        check("arst_addr",     32'(imem_addr), 32'h0010);
        check("arst_ir_valid", 32'(ir_valid),  32'd0);
        check("arst_halted",   32'(halted),    32'd0);
        check("arst_funct",    32'(funct),     32'd0);
        check("arst_kk",       32'(kk),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("arst_restart_req",  32'(imem_req),  32'd1);
        check("arst_restart_addr", 32'(imem_addr), 32'h0010);
        imem_rvalid = 1'b1;
        imem_rdata  = 16'h1234;
        step();
        imem_rvalid = 1'b0;
        check("late_rvalid_ignored", 32'(ir_valid), 32'd0);
        check("late_rvalid_req",     32'(imem_req), 32'd1);
        fetch_one(16'h0010, 16'h5A5A, PC_INC, 1'b0, 0, 0, 1'b0, 1'b0);

        step();
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("iss_q_drained",  32'(iss_q.size()),  32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch and issue unit for the 16-bit datapath. It owns the program counter and reads instruction words from instruction memory over a request/grant/response interface. It splits each word into the `operation`/`funct` and operand fields consumed by the control unit, and computes the next PC from the control unit's `pc_s` selection and the branch outcome. Only one memory request is outstanding at a time, and only one instruction is in flight.

## Interface
- `ADDR_W`, 16: instruction address width, word addressed.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out ADDR_W: fetch address. Equals `pc` and is stable while `imem_req` is high.
- `imem_gnt` in 1: memory accepted the request.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 16: instruction word.
- `ir_valid` out 1: decoded fields are valid.
- `ir_ready` in 1: downstream accepts and retires the instruction.
- `operation` out 2: `imem_rdata[15:14]`.
- `funct` out 3: `imem_rdata[13:11]`.
- `rx` out 3: `[10:8]`.
- `ry` out 3: `[7:5]`.
- `kk` out 8: `[7:0]`.
- `pc` out ADDR_W: address of the current instruction, used for the DATA_PC link value.
- `pc_s` in `pc_s_t`: next-PC select from the control unit. Sampled only on an issue handshake.
- `br_taken` in 1: branch condition. Sampled only on an issue handshake when `operation`==OP_BR.
- `halt` in 1: stop fetching after the current instruction retires.
- `halted` out 1: high while in the HALTED state.

## Operation
- States: FETCH, WAIT, ISSUE, HALTED.
- Reset state is FETCH. Reset values:
  - `pc`=`imem_addr`=RESET_PC
  - `imem_req`=0, `ir_valid`=0, `halted`=0
  - all field outputs 0
- `imem_req` and `ir_valid` are decoded from the registered state: `imem_req`=(state==FETCH), `ir_valid`=(state==ISSUE).
- FETCH: hold `imem_req`=1 and `imem_addr`=`pc` until `imem_gnt`, then go to WAIT. Any `imem_rvalid` seen in FETCH is ignored.
- WAIT: on `imem_rvalid`, register `imem_rdata` into the instruction register and go to ISSUE. `imem_gnt` is ignored in this state.
- ISSUE: field outputs are stable. Leave the state only when `ir_valid && ir_ready`. On that cycle, `pc` gets next_pc and the FSM goes to HALTED if `halt`=1, otherwise to FETCH.
- HALTED: no requests are issued and `pc` holds. Return to FETCH on the first cycle with `halt`=0.
- `halt` has no effect in FETCH or WAIT. The current instruction always completes.
- next_pc, all sums taken modulo 2^ADDR_W (wrap from max to 0 with no flag):
  - `pc_s`==PC_INC: `pc`+1.
  - `pc_s`==PC_ADD and `operation`==OP_JP: `pc` + sext(`imem_rdata[10:0]`).
  - `pc_s`==PC_ADD and `operation`==OP_BR and `br_taken`=1: `pc` + sext(`kk`).
  - `pc_s`==PC_ADD and `operation`==OP_BR and `br_taken`=0: `pc`+1.
  - Any other `pc_s`/`operation` combination: `pc`+1.
- Offsets are signed. An offset of 0 re-fetches the same address.
- Reset asserted mid-transaction, in any state, returns all registers to reset values immediately. A response to a pre-reset request that arrives while in FETCH is ignored.

## Timing
- `rst_n` deasserts: `imem_req`=1 in the first cycle after the deassertion edge.
- `imem_gnt` in cycle t: state is WAIT at t+1, and `imem_req` is 0 at t+1.
- `imem_rvalid` in cycle t: `ir_valid`=1 with fields valid at t+1 (one registered stage).
- Handshake in cycle t: updated `pc` and `imem_req`=1 (or `halted`=1) at t+1.
- Minimum instruction period is 3 cycles (gnt, rvalid, issue), with zero-wait memory responding the cycle after the grant.
- Downstream back-pressure holds ISSUE indefinitely with outputs unchanged.

## Test plan
- Reset and sequential fetch: RESET_PC=0x0010, gnt the same cycle as req, rvalid one cycle after gnt, `ir_ready`=1, `pc_s`=PC_INC. Required: `imem_addr` sequence is 0x0010, 0x0011, 0x0012, with `ir_valid` pulses every 3 cycles.
- Jump backward: instruction 0x3FFE (OP_JP, offset -2) at pc 0x0020 with PC_ADD. Required: next `imem_addr`=0x001E.
- Branch: OP_BR with kk=0x05 at pc 0x0040 and PC_ADD.
  - `br_taken`=1: next fetch at 0x0045.
  - `br_taken`=0: next fetch at 0x0041.
- Back-pressure and stalls:
  - Hold `ir_ready`=0 for 5 cycles: fields and `pc` stay constant and no `imem_req` is issued.
  - Delay gnt by 4 cycles: `imem_addr` stays stable throughout.
  - A spurious rvalid in FETCH: no `ir_valid` results.
- Wrap and halt:
  - pc 0xFFFF with PC_INC: next fetch at 0x0000.
  - `halt`=1 at the handshake: `halted`=1 the next cycle and no req.
  - Drop `halt`: req resumes the next cycle at the updated pc.
- Async reset in WAIT, then release: all outputs return to reset values without a clock edge. A late rvalid is ignored, and the fetch restarts at RESET_PC.
